// File: rtl/dmem_mmio.sv
// Data-side memory for the pipelined MIPS core: byte-enabled word RAM plus a
// peripheral page (LED, synchronised switches, 32-bit timer with compare/IRQ).
module dmem_mmio #(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'hBFD0_F000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic [3:0]  selectM,
    output logic [31:0] readdataM,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        irq_o,
    output logic        bad_addr_o
);

    localparam logic [29:0] BASE_W = MMIO_BASE[31:2];

    logic [31:0] mem [2**RAM_AW];

    logic [15:0] ledReg;
    logic [15:0] swMeta;
    logic [15:0] swSync;
    logic [31:0] count;
    logic [31:0] compare;
    logic        matchFlag;
    logic        timerEn;
    logic        irqEn;
    logic        badAddr;

    logic [29:0]       wordAddr;
    logic [RAM_AW-1:0] ramIdx;
    logic isRam, isLed, isSw, isCount, isCompare, isStatus;
    logic wordStore, wrLed, wrCount, wrCompare, wrStatus, badStore, ramWe, match;
    logic unusedByteOffset;

    assign wordAddr         = aluoutM[31:2];
    assign ramIdx           = aluoutM[RAM_AW+1:2];
    assign unusedByteOffset = ^aluoutM[1:0];

    assign isRam     = (aluoutM[31:RAM_AW+2] == '0);
    assign isLed     = (wordAddr == BASE_W);
    assign isSw      = (wordAddr == BASE_W + 30'd1);
    assign isCount   = (wordAddr == BASE_W + 30'd2);
    assign isCompare = (wordAddr == BASE_W + 30'd3);
    assign isStatus  = (wordAddr == BASE_W + 30'd4);

    // Peripheral registers only accept full-word stores.
    assign wordStore = memwriteM && (selectM == 4'b1111);
    assign wrLed     = wordStore && isLed;
    assign wrCount   = wordStore && isCount;
    assign wrCompare = wordStore && isCompare;
    assign wrStatus  = wordStore && isStatus;
    assign badStore  = memwriteM && !isRam && !(wrLed || wrCount || wrCompare || wrStatus);
    assign ramWe     = memwriteM && isRam && !rst;

    assign match = timerEn && (count == compare);

    // NOTE: the RAM array has no reset branch; resetting a memory turns it
    // into thousands of flops instead of a distributed RAM.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int i = 0; i < 4; i++) begin
                if (selectM[i]) mem[ramIdx][8*i +: 8] <= writedataM[8*i +: 8];
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ledReg    <= '0;
            swMeta    <= '0;
            swSync    <= '0;
            count     <= '0;
            compare   <= 32'hFFFF_FFFF;
            matchFlag <= 1'b0;
            timerEn   <= 1'b0;
            irqEn     <= 1'b0;
            badAddr   <= 1'b0;
        end else begin
            swMeta  <= sw_i;
            swSync  <= swMeta;
            badAddr <= badStore;
            if (wrLed) ledReg <= writedataM[15:0];
            if (wrCount)      count <= writedataM;
            else if (timerEn) count <= count + 32'd1;
            if (wrCompare) compare <= writedataM;
            if (wrStatus) begin
                timerEn <= writedataM[1];
                irqEn   <= writedataM[2];
            end
            // A new match beats a simultaneous write-1-to-clear.
            if (match)                          matchFlag <= 1'b1;
            else if (wrStatus && writedataM[0]) matchFlag <= 1'b0;
        end
    end

    // NOTE: default assigned first so no path leaves readdataM unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        readdataM = '0;
        if (isRam)          readdataM = mem[ramIdx];
        else if (isLed)     readdataM = {16'h0, ledReg};
        else if (isSw)      readdataM = {16'h0, swSync};
        else if (isCount)   readdataM = count;
        else if (isCompare) readdataM = compare;
        else if (isStatus)  readdataM = {29'h0, irqEn, timerEn, matchFlag};
    end

    assign led_o      = ledReg;
    assign irq_o      = matchFlag && irqEn;
    assign bad_addr_o = badAddr;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus randomized traffic
// compared against an address-map level reference model.
module tb_dmem_mmio;

    localparam logic [31:0] MB = 32'hBFD0_F000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memwriteM = 1'b0;
    logic [31:0] aluoutM = '0;
    logic [31:0] writedataM = '0;
    logic [3:0]  selectM = '0;
    logic [31:0] readdataM;
    logic [15:0] sw_i = '0;
    logic [15:0] led_o;
    logic        irq_o;
    logic        bad_addr_o;

    int tests = 0;
    int fails = 0;

    dmem_mmio #(.RAM_AW(10), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst(rst), .memwriteM(memwriteM), .aluoutM(aluoutM),
        .writedataM(writedataM), .selectM(selectM), .readdataM(readdataM),
        .sw_i(sw_i), .led_o(led_o), .irq_o(irq_o), .bad_addr_o(bad_addr_o)
    );

    always #10 clk = ~clk;

    // Reference model state
    logic [31:0] mRam [1024];
    logic [15:0] mLed, mSw1, mSw2;
    logic [31:0] mCount, mCmp;
    logic        mFlag, mTen, mIen, mBad;

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [31:0] off;
        if (a < 32'h1000) return mRam[a[11:2]];
        off = {a[31:2], 2'b00} - MB;
        case (off)
            32'h00:  return {16'h0, mLed};
            32'h04:  return {16'h0, mSw2};
            32'h08:  return mCount;
            32'h0C:  return mCmp;
            32'h10:  return {29'h0, mIen, mTen, mFlag};
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        logic [31:0] nRam, nCount, nCmp, off;
        logic [15:0] nLed, nSw1, nSw2;
        logic        nFlag, nTen, nIen, nBad, ramWr, hit;
        nLed = mLed; nCount = mCount; nCmp = mCmp; nFlag = mFlag;
        nTen = mTen; nIen = mIen; nSw1 = sw_i; nSw2 = mSw1; nBad = 1'b0;
        ramWr = 1'b0; nRam = '0;
        if (rst) begin
            nLed = '0; nCount = '0; nCmp = 32'hFFFF_FFFF; nFlag = 1'b0;
            nTen = 1'b0; nIen = 1'b0; nSw1 = '0; nSw2 = '0;
        end else begin
            if (mTen) nCount = mCount + 1;
            if (memwriteM) begin
                if (aluoutM < 32'h1000) begin
                    ramWr = 1'b1;
                    nRam = mRam[aluoutM[11:2]];
                    for (int i = 0; i < 4; i++)
                        if (selectM[i]) nRam[8*i +: 8] = writedataM[8*i +: 8];
                end else begin
                    off = {aluoutM[31:2], 2'b00} - MB;
                    hit = 1'b1;
                    if (selectM != 4'hF) hit = 1'b0;
                    else if (off == 32'h00) nLed = writedataM[15:0];
                    else if (off == 32'h08) nCount = writedataM;
                    else if (off == 32'h0C) nCmp = writedataM;
                    else if (off == 32'h10) begin
                        nTen = writedataM[1]; nIen = writedataM[2];
                        if (writedataM[0]) nFlag = 1'b0;
                    end else hit = 1'b0;
                    nBad = !hit;
                end
            end
            if (mTen && mCount == mCmp) nFlag = 1'b1;
        end
        @(posedge clk);
        #1;
        if (ramWr) mRam[aluoutM[11:2]] = nRam;
        mLed = nLed; mCount = nCount; mCmp = nCmp; mFlag = nFlag;
        mTen = nTen; mIen = nIen; mSw1 = nSw1; mSw2 = nSw2; mBad = nBad;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        memwriteM = 1'b1; aluoutM = a; writedataM = d; selectM = s;
        tick();
        memwriteM = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        memwriteM = 1'b0; aluoutM = a;
        #1;
        v = readdataM;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [5] = '{MB, MB + 4, MB + 8, MB + 12, MB + 16};
        logic [31:0] want [5] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (led_o !== 16'h0 || irq_o !== 1'b0 || bad_addr_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs led=%h irq=%b bad=%b want 0/0/0", led_o, irq_o, bad_addr_o);
        end
        for (int i = 0; i < 5; i++) begin
            peek(addrs[i], v);
            tests++;
            if (v !== want[i]) begin
                fails++;
                $display("FAIL reset_reg[%0d] got %h want %h", i, v, want[i]);
            end
        end
    endtask

    task automatic test_ram_lanes();
        logic [31:0] v;
        store(32'h10, 32'h1122_3344, 4'b1111);
        store(32'h10, 32'hAABB_CCDD, 4'b0101);
        peek(32'h10, v);
        tests++;
        if (v !== 32'h11BB_33DD) begin fails++; $display("FAIL ram_lanes got %h want 11bb33dd", v); end
        // Same-cycle read during a store shows the old contents.
        memwriteM = 1'b1; aluoutM = 32'h10; writedataM = 32'h0000_0055; selectM = 4'hF;
        #1;
        tests++;
        if (readdataM !== 32'h11BB_33DD) begin fails++; $display("FAIL ram_same_cycle got %h want 11bb33dd", readdataM); end
        tick();
        peek(32'h10, v);
        tests++;
        if (v !== 32'h55) begin fails++; $display("FAIL ram_next_cycle got %h want 00000055", v); end
        store(32'h0FFC, 32'hCAFE_F00D, 4'b1111);
        peek(32'h0FFC, v);
        tests++;
        if (v !== 32'hCAFE_F00D) begin fails++; $display("FAIL ram_top got %h want cafef00d", v); end
        peek(32'h1000, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL ram_beyond got %h want 0", v); end
    endtask

    task automatic test_led_switch();
        logic [31:0] v;
        store(MB, 32'h0000_A5A5, 4'b1111);
        tests++;
        if (led_o !== 16'hA5A5) begin fails++; $display("FAIL led_write got %h want a5a5", led_o); end
        sw_i = 16'h1234;
        tick();
        peek(MB + 4, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL switch_1cyc got %h want 0", v); end
        tick();
        peek(MB + 4, v);
        tests++;
        if (v !== 32'h1234) begin fails++; $display("FAIL switch_2cyc got %h want 1234", v); end
        store(MB, 32'h0000_FFFF, 4'b0011);
        tests++;
        if (led_o !== 16'hA5A5 || bad_addr_o !== 1'b1) begin
            fails++;
            $display("FAIL led_partial led=%h bad=%b want a5a5/1", led_o, bad_addr_o);
        end
        tick();
        tests++;
        if (bad_addr_o !== 1'b0) begin fails++; $display("FAIL bad_pulse_len got %b want 0", bad_addr_o); end
        store(MB + 4, 32'hFFFF_FFFF, 4'b1111);
        tests++;
        if (bad_addr_o !== 1'b1) begin fails++; $display("FAIL bad_switch_store got %b want 1", bad_addr_o); end
        store(MB + 32'h14, 32'h1, 4'b1111);
        peek(MB + 32'h14, v);
        tests++;
        if (bad_addr_o !== 1'b1 || v !== 32'h0) begin
            fails++;
            $display("FAIL unmapped bad=%b rd=%h want 1/0", bad_addr_o, v);
        end
    endtask

    task automatic test_timer_match();
        logic [31:0] v;
        store(MB + 12, 32'd5, 4'hF);
        store(MB + 8, 32'd0, 4'hF);
        store(MB + 16, 32'b110, 4'hF);
        for (int k = 0; k <= 5; k++) begin
            peek(MB + 8, v);
            tests++;
            if (v !== k || irq_o !== 1'b0) begin
                fails++;
                $display("FAIL timer_count[%0d] got %h irq=%b want %h irq=0", k, v, irq_o, k);
            end
            tick();
        end
        peek(MB + 16, v);
        tests++;
        if (v !== 32'b111 || irq_o !== 1'b1) begin
            fails++;
            $display("FAIL timer_match status=%h irq=%b want 7/1", v, irq_o);
        end
        store(MB + 16, 32'b111, 4'hF);
        peek(MB + 16, v);
        tests++;
        if (v !== 32'b110 || irq_o !== 1'b0) begin
            fails++;
            $display("FAIL timer_w1c status=%h irq=%b want 6/0", v, irq_o);
        end
    endtask

    task automatic test_wrap_collision();
        logic [31:0] v;
        logic [31:0] want [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        store(MB + 16, 32'b000, 4'hF);
        store(MB + 8, 32'hFFFF_FFFE, 4'hF);
        store(MB + 16, 32'b010, 4'hF);
        for (int k = 0; k < 3; k++) begin
            peek(MB + 8, v);
            tests++;
            if (v !== want[k]) begin fails++; $display("FAIL wrap[%0d] got %h want %h", k, v, want[k]); end
            tick();
        end
        store(MB + 8, 32'h100, 4'hF);
        peek(MB + 8, v);
        tests++;
        if (v !== 32'h100) begin fails++; $display("FAIL count_store_wins got %h want 100", v); end
        store(MB + 16, 32'b000, 4'hF);
        store(MB + 8, 32'h10, 4'hF);
        store(MB + 12, 32'h11, 4'hF);
        store(MB + 16, 32'b010, 4'hF);
        tick();
        tick();
        store(MB + 8, 32'h11, 4'hF);
        store(MB + 16, 32'b011, 4'hF);
        peek(MB + 16, v);
        tests++;
        if (v !== 32'b011) begin fails++; $display("FAIL w1c_vs_match got %h want 3", v); end
        store(MB + 16, 32'b011, 4'hF);
        peek(MB + 16, v);
        tests++;
        if (v !== 32'b010) begin fails++; $display("FAIL w1c_after got %h want 2", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic [31:0] addrs [5] = '{MB + 8, MB + 12, MB + 16, MB + 4, MB};
        logic [31:0] want [5] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        store(MB, 32'hFFFF, 4'hF);
        store(MB + 16, 32'b000, 4'hF);
        store(MB + 8, 32'h0, 4'hF);
        store(MB + 12, 32'h2, 4'hF);
        store(MB + 16, 32'b110, 4'hF);
        sw_i = 16'hBEEF;
        for (int k = 0; k < 4; k++) tick();
        tests++;
        if (irq_o !== 1'b1 || led_o !== 16'hFFFF) begin
            fails++;
            $display("FAIL pre_reset irq=%b led=%h want 1/ffff", irq_o, led_o);
        end
        rst = 1'b1;
        store(MB, 32'h1234, 4'hF);
        rst = 1'b0;
        tests++;
        if (led_o !== 16'h0 || irq_o !== 1'b0 || bad_addr_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_out led=%h irq=%b bad=%b want 0/0/0", led_o, irq_o, bad_addr_o);
        end
        for (int i = 0; i < 5; i++) begin
            peek(addrs[i], v);
            tests++;
            if (v !== want[i]) begin fails++; $display("FAIL mid_reset_reg[%0d] got %h want %h", i, v, want[i]); end
        end
        for (int k = 0; k < 3; k++) tick();
        peek(MB + 8, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL count_hold got %h want 0", v); end
        store(MB + 16, 32'b010, 4'hF);
        tick();
        peek(MB + 8, v);
        tests++;
        if (v !== 32'h1) begin fails++; $display("FAIL count_restart got %h want 1", v); end
    endtask

    task automatic test_random();
        logic [31:0] offs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        logic [31:0] a, d, exp;
        logic [3:0]  s;
        int          op;
        for (int i = 0; i < 16; i++) store(32'h100 + 4 * i, $urandom, 4'hF);
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 7);
            sw_i = 16'($urandom);
            memwriteM = 1'b0;
            d = $urandom;
            s = 4'hF;
            if (op < 4) begin
                a = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                s = 4'($urandom);
                memwriteM = (op < 2);
            end else begin
                a = MB + offs[$urandom_range(0, 5)];
                memwriteM = (op == 4);
                if ($urandom_range(0, 3) == 0) s = 4'($urandom);
                if (a == MB + 12) d = mCount + $urandom_range(0, 12);
                if (a == MB + 8 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                if (a == MB + 16) d = $urandom_range(0, 7);
            end
            aluoutM = a; writedataM = d; selectM = s;
            #1;
            exp = mread(a);
            tests++;
            if (readdataM !== exp) begin fails++; $display("FAIL rand_read[%0d] a=%h got %h want %h", n, a, readdataM, exp); end
            tests++;
            if (led_o !== mLed || irq_o !== (mFlag && mIen) || bad_addr_o !== mBad) begin
                fails++;
                $display("FAIL rand_outs[%0d] led=%h irq=%b bad=%b want %h/%b/%b",
                         n, led_o, irq_o, bad_addr_o, mLed, mFlag && mIen, mBad);
            end
            tick();
        end
        memwriteM = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_ram_lanes();
        test_led_switch();
        test_timer_match();
        test_wrap_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory subsystem for the pipelined MIPS core: consumes the core's memory-stage outputs (memwriteM, aluoutM, writedataM, selectM) and returns readdataM. Decodes each access to a byte-enabled data RAM or to a small memory-mapped peripheral set: LED register, synchronised switch input, and a 32-bit timer with compare, sticky match flag and interrupt. Sits directly downstream of the core's M stage, in the SoC top beside the instruction ROM.

## Interface

Parameters:
- RAM_AW, 10, RAM word-address width (1024 x 32-bit words, byte range 0x0000_0000–0x0000_0FFF)
- MMIO_BASE, 32'hBFD0_F000, base byte address of the peripheral page

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- memwriteM  in  1  store strobe for the current M-stage access
- aluoutM  in  32  byte address of the access
- writedataM  in  32  store data, lane i = bits [8i+7:8i]
- selectM  in  4  byte enables, bit i enables lane i
- readdataM  out  32  load data for aluoutM, combinational, same cycle
- sw_i  in  16  asynchronous board switches
- led_o  out  16  LED register value
- irq_o  out  1  timer interrupt = match flag AND irq-enable
- bad_addr_o  out  1  registered one-cycle pulse on an illegal store

## Operation

- Address decode on aluoutM (byte address, bits [1:0] ignored for selection):
  - RAM: aluoutM[31:RAM_AW+2] == 0; word index aluoutM[RAM_AW+1:2].
  - MMIO_BASE+0x00 LED (RW, bits [15:0]; reads zero-extended).
  - +0x04 SWITCH (RO): sw_i through two flops, zero-extended.
  - +0x08 COUNT (RW), +0x0C COMPARE (RW).
  - +0x10 STATUS: bit0 match flag (read; write 1 clears), bit1 timer enable (RW), bit2 irq enable (RW); other bits read 0.
  - Anything else: unmapped, reads 0.
- RAM: store writes only lanes with selectM[i]=1; read is asynchronous (distributed array), full word returned; core extracts bytes/halves. RAM contents not reset.
- MMIO stores are word-only: take effect only when selectM == 4'b1111. Partial MMIO store, store to SWITCH, or store to unmapped address: no state change, bad_addr_o pulses next cycle.
- Timer (enable=1): COUNT increments by 1 per cycle, wraps 0xFFFF_FFFF -> 0. When COUNT == COMPARE in a cycle with enable=1, flag sets at the next edge. Enable=0: COUNT holds, no match detection.
- Simultaneous events, same edge:
  - COUNT store vs. increment: store wins, loaded value not incremented that cycle.
  - Flag W1C vs. new match: set wins, flag stays 1.
  - STATUS store writes enable bits and W1C together.
- Load with memwriteM=0 never changes state (no read side effects).

## Timing

- All stores commit at the rising edge of the cycle memwriteM=1; a load to the same address in the next cycle returns the new value (no write-to-read forwarding needed within a cycle; same-cycle readdataM shows old contents).
- readdataM: purely combinational from aluoutM and current state, zero cycle latency.
- Switch path: sw_i change visible on SWITCH read 2 cycles later.
- Match: COUNT==COMPARE in cycle N -> flag=1 and irq_o (if irq-enable) high in cycle N+1; stays high until cleared.
- bad_addr_o: high exactly one cycle after the offending store.
- Reset (rst high at an edge, any time, including mid-count): led_o=0, COUNT=0, COMPARE=0xFFFF_FFFF, STATUS=0 (flag, enables clear), switch sync flops=0, irq_o=0, bad_addr_o=0. Reset overrides any concurrent store.

## Test plan

- RAM byte lanes: store 0x11223344 to 0x0000_0010 sel 1111, then 0xAABBCCDD sel 0101 -> load returns 0x11BB33DD; store to 0x0000_0FFC then load 0x0000_0FFC returns value, address 0x0000_1000 reads 0.
- LED/switch: word store 0x0000_A5A5 to MMIO_BASE -> led_o=0xA5A5 next cycle; sw_i=0x1234 -> SWITCH read 0x0000_1234 after 2 cycles; sel 0011 store to LED -> led_o unchanged, bad_addr_o pulses once.
- Timer match: COMPARE=5, COUNT=0, STATUS=0b110 -> flag and irq_o rise the cycle after COUNT==5; write STATUS=0b111 -> flag clears, irq_o low, enables kept.
- Wrap and collision: COUNT=0xFFFF_FFFE, enable -> reads 0xFFFF_FFFF then 0x0000_0000; store COUNT=0x100 while counting -> next read 0x100; W1C in same cycle as match -> flag remains 1.
- Reset mid-operation: timer running, flag set, LED=0xFFFF, assert rst one cycle -> all outputs and registers at reset values, COMPARE reads 0xFFFF_FFFF, COUNT holds 0 until enable rewritten.
